mem_port_arb: RTL
=================

// Module: mem_port_arb
// PURPOSE
//  Shares one ram_int_4p port between two write requesters (left/right camera frame buffers) and two read
//  requesters (left/right display readers). Round-robin arbiter with a registered issue stage; routes
//  in-order read returns to the owning reader via an outstanding-read tag FIFO. Sits between the
//  frame_buf_alt instances and the LPDDR2 memory interface in the stereoscopic image capture top level.
// PARAMETERS
//  ADDR_W     24  word address width, both requester and memory sides
//  DATA_W     32  data width
//  MAX_OUTST  8   max reads issued but not returned; power of 2, >=2
// PORTS
//  clk           in   1           sole clock; all logic on posedge
//  reset         in   1           synchronous, active-high
//  w_req         in   2           write request per writer [0]=left [1]=right; held until granted
//  w_addr        in   2*ADDR_W    packed write addresses, writer i at [i*ADDR_W +: ADDR_W]
//  w_data        in   2*DATA_W    packed write data, writer i at [i*DATA_W +: DATA_W]
//  w_gnt         out  2           one-cycle pulse: writer i accepted
//  r_req         in   2           read request per reader; held until granted
//  r_addr        in   2*ADDR_W    packed read addresses
//  r_gnt         out  2           one-cycle pulse: reader i accepted
//  r_valid       out  2           one-cycle pulse: r_data belongs to reader i
//  r_data        out  DATA_W      read data, broadcast to both readers
//  mem_wr_en     out  1           write strobe to memory port
//  mem_wr_addr   out  ADDR_W      write address
//  mem_wr_data   out  DATA_W      write data
//  mem_rd_en     out  1           read strobe to memory port
//  mem_rd_addr   out  ADDR_W      read address
//  mem_wr_rdy    in   1           memory can accept a write this cycle
//  mem_rd_rdy    in   1           memory can accept a read this cycle
//  mem_rd_valid  in   1           one-cycle strobe per returned word, in issue order
//  mem_rd_data   in   DATA_W      returned word, valid with mem_rd_valid
//  outst_cnt     out  log2(MAX_OUTST)+1  reads in flight
//  err_orphan    out  1           sticky: mem_rd_valid seen with no read in flight
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; RR pointer=0 (W0); tag FIFO empty; err_orphan cleared.
//  Requester index order: 0=W0 1=W1 2=R0 3=R1. Eligible: W* if w_req & mem_wr_rdy;
//   R* if r_req & mem_rd_rdy & outst_cnt<MAX_OUTST.
//  FSM IDLE: pick first eligible index scanning from pointer upward, mod 4; latch index, addr, data;
//   go ISSUE. No eligible requester -> stay IDLE.
//  FSM ISSUE (exactly 1 cycle): pulse the matching gnt bit and mem_wr_en or mem_rd_en with the latched
//   addr/data; reads push the reader id into the tag FIFO; pointer <= winner+1 mod 4; return to IDLE.
//  Latency req->gnt/strobe: 2 cycles min; throughput: 1 transfer per 2 cycles. Never >1 gnt or
//   >1 mem strobe per cycle; mem_wr_en and mem_rd_en never both high.
//  mem_wr_rdy/mem_rd_rdy are sampled only in IDLE; a drop during ISSUE does not cancel the issue.
//  Return path: mem_rd_valid pops the FIFO head; r_valid[head]<=1 and r_data<=mem_rd_data,
//   registered (1-cycle latency). FIFO empty on mem_rd_valid -> word dropped, err_orphan<=1.
//  Push (ISSUE) and pop in the same cycle: outst_cnt unchanged; both take effect. FIFO pointers
//   wrap mod MAX_OUTST.
//  outst_cnt==MAX_OUTST: readers ineligible; writers still served.
//  reset asserted mid-transfer: FSM to IDLE, in-flight tags discarded, no strobe on the following
//   cycle; late returns after reset set err_orphan.
// STRUCTURE
//  Package img_cap_pkg: requester index constants (REQ_W0..REQ_R1), NUM_REQ=4, reader-id width.
//  Sub-module mem_tag_fifo (DEPTH=MAX_OUTST, WIDTH=1): sync FIFO with push/pop/full/empty/count;
//   simultaneous push+pop legal when not empty.
//  Arbiter, FSM and issue registers stay in mem_port_arb.
// TESTING
//  All 4 reqs held, rdy=1 -> gnt order W0,W1,R0,R1,W0..., each gnt 2 cycles apart, addr/data matched.
//  W0 only, w_addr=24'h000007, w_data=32'h00FFFFFF -> mem_wr_en pulse 2 cycles later, exact values.
//  R0,R1 alternate, memory returns 3 cycles after rd_en -> r_valid bit matches issuing reader each word.
//  MAX_OUTST=8, no returns -> 8 r_gnt then stall; W0 still granted; 1 return -> 1 more r_gnt.
//  mem_rd_valid with nothing in flight -> no r_valid, err_orphan=1 until reset.
//  reset in ISSUE cycle with R1 winning -> no rd_en next cycle; outst_cnt=0; pointer=0.

Source files
------------

// File: rtl/img_cap_pkg.sv
// img_cap_pkg: requester indices, arbiter state type and round-robin pick helper for mem_port_arb
package img_cap_pkg;
  localparam int NUM_REQ   = 4;
  localparam int REQ_IDX_W = 2;
  localparam int RID_W     = 1;
  localparam int REQ_W0    = 0;
  localparam int REQ_W1    = 1;
  localparam int REQ_R0    = 2;
  localparam int REQ_R1    = 3;
  typedef enum logic {IDLE, ISSUE} arb_state_t;
  function automatic logic [REQ_IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] elig, input logic [REQ_IDX_W-1:0] ptr);
    logic [REQ_IDX_W-1:0] w, k;
    w = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = ptr + REQ_IDX_W'(i);
      if (elig[k]) w = k;
    end
    return w;
  endfunction
endpackage

// File: rtl/mem_tag_fifo.sv
// mem_tag_fifo: sync FIFO (clk, reset, push/din in, pop in, dout/full/empty/count out); push+pop together legal
module mem_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign dout    = mem_q[rp_q];
  assign count   = cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(do_push);
      rp_q  <= rp_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end
endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: round-robin share of one memory port by writers w_* and readers r_*; issues on mem_*, routes returns to r_valid/r_data, reports outst_cnt/err_orphan
module mem_port_arb
  import img_cap_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 w_req,
  input  logic [2*ADDR_W-1:0]        w_addr,
  input  logic [2*DATA_W-1:0]        w_data,
  output logic [1:0]                 w_gnt,
  input  logic [1:0]                 r_req,
  input  logic [2*ADDR_W-1:0]        r_addr,
  output logic [1:0]                 r_gnt,
  output logic [1:0]                 r_valid,
  output logic [DATA_W-1:0]          r_data,
  output logic                       mem_wr_en,
  output logic [ADDR_W-1:0]          mem_wr_addr,
  output logic [DATA_W-1:0]          mem_wr_data,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          mem_rd_addr,
  input  logic                       mem_wr_rdy,
  input  logic                       mem_rd_rdy,
  input  logic                       mem_rd_valid,
  input  logic [DATA_W-1:0]          mem_rd_data,
  output logic [$clog2(MAX_OUTST):0] outst_cnt,
  output logic                       err_orphan
);
  arb_state_t state_q;
  logic [REQ_IDX_W-1:0] ptr_q, win_q, win;
  logic [NUM_REQ-1:0] elig;
  logic [RID_W-1:0] head;
  logic full, empty, pop;
  assign elig = {r_req & {2{mem_rd_rdy & ~full}}, w_req & {2{mem_wr_rdy}}};
  assign win  = rr_pick(elig, ptr_q);
  assign pop  = mem_rd_valid & ~empty;
  // index bit 1 selects reader vs writer, bit 0 selects which one
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= REQ_IDX_W'(REQ_W0);
      win_q       <= REQ_IDX_W'(REQ_W0);
      w_gnt       <= '0;
      r_gnt       <= '0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_rd_addr <= '0;
    end else begin
      w_gnt     <= '0;
      r_gnt     <= '0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
      if (state_q == ISSUE) begin
        state_q <= IDLE;
        ptr_q   <= win_q + 2'd1;
      end else if (|elig) begin
        state_q     <= ISSUE;
        win_q       <= win;
        w_gnt       <= win[1] ? 2'b00 : {win[0], ~win[0]};
        r_gnt       <= win[1] ? {win[0], ~win[0]} : 2'b00;
        mem_wr_en   <= ~win[1];
        mem_rd_en   <= win[1];
        mem_wr_addr <= win[0] ? w_addr[2*ADDR_W-1:ADDR_W] : w_addr[ADDR_W-1:0];
        mem_wr_data <= win[0] ? w_data[2*DATA_W-1:DATA_W] : w_data[DATA_W-1:0];
        mem_rd_addr <= win[0] ? r_addr[2*ADDR_W-1:ADDR_W] : r_addr[ADDR_W-1:0];
      end
    end
  end
  mem_tag_fifo #(.DEPTH(MAX_OUTST), .WIDTH(RID_W)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (mem_rd_en),
    .pop   (pop),
    .din   (win_q[RID_W-1:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outst_cnt)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= '0;
      r_data     <= '0;
      err_orphan <= 1'b0;
    end else begin
      r_valid    <= {pop & head[0], pop & ~head[0]};
      r_data     <= pop ? mem_rd_data : r_data;
      err_orphan <= err_orphan | (mem_rd_valid & empty);
    end
  end
endmodule
